// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
//   - Default geometry (DEFAULT_DEPTH words, DEFAULT_LAT edges of access latency).
//   - FSM state encoding, kept as plain localparams so older tools can consume it.
//   - idx_width(): number of word-index bits for a given depth.
// No ports: package only.
package dmem_pkg;

  localparam int unsigned DEFAULT_DEPTH = 256;
  localparam int unsigned DEFAULT_LAT   = 2;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StWait = 2'd1;
  localparam state_t StResp = 2'd2;

  // Word-index width; a depth of 1 still needs one index bit to form a legal vector.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit single-port storage for dmem_responder.
// Ports:
//   clk, rst   - clock (rising edge) and asynchronous active-low reset (read register only)
//   we_i       - write enable, commits wdata_i to addr_i on the clock edge
//   re_i       - read enable, registers mem[addr_i] into rdata_o on the clock edge
//   clr_i      - clears rdata_o (stores, rejected accesses, response handshake)
//   addr_i     - word index
//   wdata_i    - write data
//   rdata_o    - registered read data
// The storage itself is deliberately not reset; only the read register is.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned IdxW  = idx_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic            re_i,
  input  logic            clr_i,
  input  logic [IdxW-1:0] addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  // A read takes priority; the responder never asserts both in one cycle anyway.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem[addr_i];
    end else if (clr_i) begin
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time over valid/ready,
// access performed LAT edges after acceptance, response returned over valid/ready.
// Ports:
//   clk, rst                     - clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready          - request handshake
//   req_write, req_addr, req_wdata - 1 = store; byte address; store data
//   resp_valid/resp_ready        - response handshake
//   resp_rdata, resp_err         - load data (0 for stores/errors); access rejected
//   busy                         - a transaction is in flight
// Optional feature: define DMEM_MISALIGN_CHECK_EN to reject addresses with
// req_addr[1:0] != 0. Without it the low address bits are ignored.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned LAT   = DEFAULT_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned IdxW = idx_width(DEPTH);
  localparam int unsigned CntW = $clog2(LAT) + 1;
  localparam logic [CntW-1:0] CntInit = CntW'(LAT - 1);

  state_t          state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            write_d, write_q;
  logic [31:0]     addr_d, addr_q;
  logic [31:0]     wdata_d, wdata_q;
  logic            err_d, err_q;

  logic commit;
  logic resp_done;
  logic addr_oor;
  logic acc_err;

  // Power-of-two depth: any set bit above the word index means out of range.
  assign addr_oor = |addr_q[31:IdxW+2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign acc_err = addr_oor | (addr_q[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_q[1:0];
  assign acc_err = addr_oor;
`endif

  assign commit    = (state_q == StWait) && (cnt_q == '0);
  assign resp_done = (state_q == StResp) && resp_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CntInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          err_d   = acc_err;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (resp_ready) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Commit happens on the WAIT->RESP edge, so a following load always sees it.
  dmem_array #(
    .DEPTH (DEPTH),
    .IdxW  (IdxW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (commit & write_q & ~acc_err),
    .re_i    (commit & ~write_q & ~acc_err),
    .clr_i   ((commit & (write_q | acc_err)) | resp_done),
    .addr_i  (addr_q[IdxW+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (resp_rdata)
  );

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_err   = err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH=256, LAT=2): directed scenarios
// followed by random traffic, checked against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_store_addr = 32'h0;

  dmem_responder #(
    .DEPTH (DEPTH),
    .LAT   (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction. Starts one cycle after the previous handshake edge (checking the
  // idle/cleared outputs there), ends right after its own handshake edge.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input int stall, output int acc_cyc);
    bit          e;
    logic [31:0] er;
    int          idx;
    e   = (addr >= DEPTH * 4) || (MisEn && (addr[1:0] != 2'b00));
    idx = int'((addr >> 2) % DEPTH);
    er  = '0;
    if (!e && !wr) er = mem_m[idx];
    if (!e && wr) begin
      mem_m[idx]      = wd;
      last_store_addr = addr;
    end

    @(negedge clk);
    check1("idle_req_ready", req_ready, 1'b1);
    check1("idle_resp_valid", resp_valid, 1'b0);
    check32("idle_rdata", resp_rdata, 32'h0);
    check1("idle_err", resp_err, 1'b0);
    check1("idle_busy", busy, 1'b0);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    // Garbage after acceptance, with req_valid kept high: must be ignored.
    req_write = 1'b1;
    req_addr  = $urandom_range(0, DEPTH * 4 - 1);
    req_wdata = $urandom;
    for (int k = 0; k < LAT; k++) begin
      if (k != 0) @(negedge clk);
      check1("wait_resp_valid", resp_valid, 1'b0);
      check1("wait_req_ready", req_ready, 1'b0);
      check1("wait_busy", busy, 1'b1);
    end
    @(negedge clk);
    check1("resp_valid_at_lat", resp_valid, 1'b1);
    check32("resp_rdata", resp_rdata, er);
    check1("resp_err", resp_err, e);
    check1("resp_req_ready", req_ready, 1'b0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check1("stall_resp_valid", resp_valid, 1'b1);
      check32("stall_rdata", resp_rdata, er);
      check1("stall_err", resp_err, e);
      check1("stall_req_ready", req_ready, 1'b0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    int acc;
    int prev;
    logic [31:0] a;

    // Reset state.
    repeat (2) @(negedge clk);
    check1("rst_resp_valid", resp_valid, 1'b0);
    check32("rst_rdata", resp_rdata, 32'h0);
    check1("rst_err", resp_err, 1'b0);
    check1("rst_busy", busy, 1'b0);
    rst = 1'b1;

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 0, acc);

    // Store then load.
    txn(1'b1, 32'h10, 32'hDEADBEEF, 0, acc);
    txn(1'b0, 32'h10, 32'h0, 0, acc);
    check32("model_deadbeef", mem_m[4], 32'hDEADBEEF);

    // Response backpressure.
    txn(1'b0, 32'h20, 32'h0, 5, acc);

    // Out-of-range store leaves word 0 untouched.
    txn(1'b1, 32'h400, 32'h12345678, 0, acc);
    txn(1'b0, 32'h0, 32'h0, 0, acc);

    // Reset during WAIT abandons the store.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h8;
    req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check1("midrst_resp_valid", resp_valid, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check32("midrst_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    check1("postrst_resp_valid", resp_valid, 1'b0);
    check1("postrst_req_ready", req_ready, 1'b1);
    txn(1'b0, 32'h8, 32'h0, 0, acc);

    // Back-to-back loads with immediate response acceptance.
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      txn(1'b0, a, 32'h0, 0, acc);
      if (i != 0) check32("b2b_spacing", 32'(acc - prev), 32'(LAT + 2));
      prev = acc;
    end

    // Misaligned load (expectation depends on the build).
    txn(1'b0, 32'h13, 32'h0, 0, acc);

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      int unsigned r;
      r = $urandom_range(0, 7);
      if (r <= 4)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (r == 5) a = 32'($urandom_range(0, DEPTH * 4 - 1));
      else if (r == 6) a = $urandom | 32'(DEPTH * 4);
      else             a = last_store_addr;
      txn(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)), acc);
    end

    @(negedge clk);
    check1("final_idle", req_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
